// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
//             Scans one digit per slot of 2**SLOT_W sclk cycles, leftmost
//             digit first, with per-digit decimal point / blank / blink, PWM
//             brightness, leading-zero suppression and optional hex decode.
//             All display inputs are snapshotted once per frame so a frame
//             never shows a mix of old and new values.
//  Ports    : sclk, reset (async, active-high)
//             digits      [4*NUM_DIGITS-1:0]  digit i = digits[4i+3:4i]
//             dp_in, blank_mask, blink_mask [NUM_DIGITS-1:0]
//             brightness  [BRIGHT_W-1:0]      0 = dimmest, all-ones = full
//             lz_suppress                     blank leading zeros
//             seg[6:0] {g..a}, dp, an[NUM_DIGITS-1:0]   all active-low
//             frame_start                     1-cycle pulse at frame start
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_W       = 4,
    parameter int BRIGHT_W     = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int HEX_EN       = 0
) (
    input  logic                      sclk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [BRIGHT_W-1:0]       brightness,
    input  logic                      lz_suppress,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_start
);

    localparam int c_IDX_W  = $clog2(NUM_DIGITS);
    localparam int c_FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int c_SHIFT  = SLOT_W - BRIGHT_W;

    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0]   c_LAST_SCNT = {SLOT_W{1'b1}};
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(BLINK_FRAMES - 1);
    localparam logic [SLOT_W:0]     c_ON_ONE    = (SLOT_W+1)'(1);
    localparam logic [6:0]          c_DARK      = 7'h7F;
    localparam logic [6:0]          c_DASH      = 7'b0111111;

    // Scan state
    logic [SLOT_W-1:0]         scnt_q, scnt_d;
    logic [c_IDX_W-1:0]        idx_q, idx_d;
    logic [c_FCNT_W-1:0]       fcnt_q, fcnt_d;
    logic                      phase_q, phase_d;     // 1 = blink ON
    logic                      frame_start_q, frame_start_d;

    // Frame snapshot
    logic [4*NUM_DIGITS-1:0]   snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]     snap_blank_q, snap_blank_d;
    logic [NUM_DIGITS-1:0]     snap_blink_q, snap_blink_d;
    logic [BRIGHT_W-1:0]       snap_bright_q, snap_bright_d;
    logic                      snap_lz_q, snap_lz_d;

    // Registered pins
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;

    // Combinational helpers
    logic                      w_frame_edge;
    logic [NUM_DIGITS-1:0]     w_supp;
    logic                      w_zero_run;
    logic [3:0]                w_code;
    logic                      w_dp_sel;
    logic                      w_dark;
    logic                      w_on;
    logic [SLOT_W:0]           w_bright_ext;
    logic [SLOT_W:0]           w_on_lim;

    function automatic logic [6:0] f_decode(input logic [3:0] code);
        logic [6:0] pat;
        pat = c_DASH;
        case (code)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = (HEX_EN != 0) ? 7'b0001000 : c_DASH;
            4'hB: pat = (HEX_EN != 0) ? 7'b0000011 : c_DASH;
            4'hC: pat = (HEX_EN != 0) ? 7'b1000110 : c_DASH;
            4'hD: pat = (HEX_EN != 0) ? 7'b0100001 : c_DASH;
            4'hE: pat = (HEX_EN != 0) ? 7'b0000110 : c_DASH;
            4'hF: pat = (HEX_EN != 0) ? 7'b0001110 : c_DASH;
            default: pat = c_DASH;
        endcase
        return pat;
    endfunction

    always_comb begin
        // Slot counter and scan index
        scnt_d = scnt_q + 1'b1;
        idx_d  = idx_q;
        if (scnt_q == c_LAST_SCNT) begin
            idx_d = (idx_q == '0) ? c_LAST_IDX : idx_q - 1'b1;
        end

        // Snapshot is taken at the end of the cycle that sits at scnt 0 of the
        // leftmost slot. Coming out of reset that cycle is the reset state
        // itself, so the very first frame already shows live inputs.
        w_frame_edge  = (scnt_q == '0) && (idx_q == c_LAST_IDX);
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_blank_d  = snap_blank_q;
        snap_blink_d  = snap_blink_q;
        snap_bright_d = snap_bright_q;
        snap_lz_d     = snap_lz_q;
        if (w_frame_edge) begin
            snap_digits_d = digits;
            snap_dp_d     = dp_in;
            snap_blank_d  = blank_mask;
            snap_blink_d  = blink_mask;
            snap_bright_d = brightness;
            snap_lz_d     = lz_suppress;
        end

        // Blink frame counter only advances on real frame boundaries, so the
        // first frame after reset counts as frame 0.
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_start_q) begin
            if (fcnt_q == c_FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        // Pins are registered from the next-state values so that the pin
        // pattern for (slot, scnt) is visible during that very cycle.
        frame_start_d = (scnt_d == '0) && (idx_d == c_LAST_IDX);

        // Leading-zero run, scanned from the leftmost digit downwards.
        w_zero_run = 1'b1;
        w_supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (snap_digits_d[4*i +: 4] == 4'd0) && !snap_dp_d[i];
            w_supp[i]  = snap_lz_d && w_zero_run && (i != 0);
        end

        // Select the digit being scanned next cycle.
        w_code   = 4'd0;
        w_dp_sel = 1'b0;
        w_dark   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == c_IDX_W'(i)) begin
                w_code   = snap_digits_d[4*i +: 4];
                w_dp_sel = snap_dp_d[i];
                w_dark   = snap_blank_d[i] || w_supp[i] || (snap_blink_d[i] && !phase_d);
            end
        end

        // PWM window inside the slot; scnt 0 stays dark as a dead cycle.
        w_bright_ext = {{(SLOT_W + 1 - BRIGHT_W){1'b0}}, snap_bright_d};
        w_on_lim     = (w_bright_ext + c_ON_ONE) << c_SHIFT;
        w_on         = ((scnt_d != '0) && ({1'b0, scnt_d} < w_on_lim)) ||
                       ((scnt_d == c_LAST_SCNT) && (&snap_bright_d));

        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = !(w_on && (idx_d == c_IDX_W'(i)));
        end
        seg_d = w_dark ? c_DARK : f_decode(w_code);
        dp_d  = w_dark ? 1'b1 : !w_dp_sel;
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            scnt_q        <= '0;
            idx_q         <= c_LAST_IDX;
            fcnt_q        <= '0;
            phase_q       <= 1'b1;
            frame_start_q <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
            snap_blink_q  <= '0;
            snap_bright_q <= '0;
            snap_lz_q     <= 1'b0;
            seg_q         <= c_DARK;
            dp_q          <= 1'b1;
            an_q          <= '1;
        end else begin
            scnt_q        <= scnt_d;
            idx_q         <= idx_d;
            fcnt_q        <= fcnt_d;
            phase_q       <= phase_d;
            frame_start_q <= frame_start_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
            snap_blink_q  <= snap_blink_d;
            snap_bright_q <= snap_bright_d;
            snap_lz_q     <= snap_lz_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Self-checking bench for seg7_scan_driver (4 digits, 16-cycle
//             slots, 2-bit brightness, 2-frame blink). Each frame to be
//             checked gets an expected-picture entry queued when its inputs
//             are driven; a monitor pops one entry per frame and checks every
//             cycle of that frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam logic [6:0] c_ZERO  = 7'h40, c_ONE  = 7'h79, c_TWO   = 7'h24;
    localparam logic [6:0] c_THREE = 7'h30, c_FOUR = 7'h19, c_FIVE  = 7'h12;
    localparam logic [6:0] c_SIX   = 7'h02, c_SEVEN = 7'h78, c_EIGHT = 7'h00;
    localparam logic [6:0] c_DASH  = 7'h3F, c_DARK = 7'h7F, c_HEX_C = 7'h46;

    typedef struct packed {
        logic [27:0] segs;    // digit j pattern at segs[7j+:7]
        logic [3:0]  dps;     // expected dp pin per digit when lit
        logic [1:0]  bright;
    } frame_t;

    logic        sclk;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_in, blank_mask, blink_mask;
    logic [1:0]  brightness;
    logic        lz_suppress;
    logic [6:0]  seg, seg_h;
    logic        dp, dp_h, frame_start, frame_start_h;
    logic [3:0]  an, an_h;

    int          total = 0;
    int          bad   = 0;
    frame_t      exp_q[$];
    logic        busy = 1'b0;
    logic        rel_flag = 1'b0;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SLOT_W(4), .BRIGHT_W(2), .BLINK_FRAMES(2), .HEX_EN(0)
    ) dut (
        .sclk(sclk), .reset(reset), .digits(digits), .dp_in(dp_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .brightness(brightness),
        .lz_suppress(lz_suppress), .seg(seg), .dp(dp), .an(an),
        .frame_start(frame_start)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SLOT_W(4), .BRIGHT_W(2), .BLINK_FRAMES(2), .HEX_EN(1)
    ) dut_hex (
        .sclk(sclk), .reset(reset), .digits(digits), .dp_in(dp_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .brightness(brightness),
        .lz_suppress(lz_suppress), .seg(seg_h), .dp(dp_h), .an(an_h),
        .frame_start(frame_start_h)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    function automatic frame_t mk(input logic [6:0] s3, input logic [6:0] s2,
                                  input logic [6:0] s1, input logic [6:0] s0,
                                  input logic [3:0] dps, input logic [1:0] br);
        frame_t f;
        f.segs   = {s3, s2, s1, s0};
        f.dps    = dps;
        f.bright = br;
        return f;
    endfunction

    // Checks every cycle of one frame, starting at scnt = s0 of the leftmost
    // slot; called at the falling edge of that first cycle.
    task automatic check_frame(input frame_t d, input int s0);
        int  lim;
        logic lit;
        logic [3:0] an_req;
        lim = (int'(d.bright) + 1) * 4;
        for (int j = 3; j >= 0; j--) begin
            for (int s = ((j == 3) ? s0 : 0); s < 16; s++) begin
                if (!(j == 3 && s == s0)) @(negedge sclk);
                lit    = ((s >= 1) && (s < lim)) || ((s == 15) && (d.bright == 2'd3));
                an_req = lit ? ~(4'b0001 << j) : 4'hF;
                chk($sformatf("an d%0d s%0d", j, s), an, an_req);
                chk($sformatf("frame_start d%0d s%0d", j, s), frame_start,
                    (j == 3 && s == 0) ? 1 : 0);
                if (lit) begin
                    chk($sformatf("seg d%0d s%0d", j, s), seg, d.segs[7*j +: 7]);
                    chk($sformatf("dp d%0d s%0d", j, s), dp, d.dps[j]);
                end
            end
        end
    endtask

    // Monitor: one queued picture per frame.
    initial begin
        frame_t d;
        forever begin
            @(negedge sclk);
            if (!reset && exp_q.size() > 0) begin
                if (rel_flag) begin
                    busy     = 1'b1;
                    rel_flag = 1'b0;
                    d = exp_q.pop_front();
                    check_frame(d, 1);
                    busy = 1'b0;
                end else if (frame_start === 1'b1) begin
                    busy = 1'b1;
                    d = exp_q.pop_front();
                    check_frame(d, 0);
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic wait_q_empty(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge sclk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge sclk);
            n++;
        end
        chk(tag, (exp_q.size() == 0 && !busy) ? 1 : 0, 1);
    endtask

    task automatic wait_an(input string tag, input logic [3:0] want, input logic hex);
        int n = 0;
        while (((hex ? an_h : an) !== want) && n < 200) begin
            @(negedge sclk);
            n++;
        end
        chk(tag, hex ? an_h : an, want);
    endtask

    // Drive the inputs for the next frame right after the current frame's
    // snapshot edge, and queue the picture that frame must show.
    task automatic step(input logic [15:0] dg, input logic [3:0] dpv,
                        input logic [3:0] bl, input logic [3:0] bk,
                        input logic [1:0] br, input logic lz, input frame_t f);
        wait_q_empty("frame sync");
        @(posedge sclk);
        #1;
        digits      = dg;
        dp_in       = dpv;
        blank_mask  = bl;
        blink_mask  = bk;
        brightness  = br;
        lz_suppress = lz;
        exp_q.push_back(f);
    endtask

    initial begin
        frame_t f1234, f1234_b0dark;
        f1234        = mk(c_ONE, c_TWO, c_THREE, c_FOUR, 4'hF, 2'd3);
        f1234_b0dark = mk(c_ONE, c_TWO, c_THREE, c_DARK, 4'hF, 2'd3);

        reset       = 1'b1;
        digits      = 16'h1234;
        dp_in       = 4'h0;
        blank_mask  = 4'h0;
        blink_mask  = 4'h0;
        brightness  = 2'd3;
        lz_suppress = 1'b0;

        // Reset values
        repeat (2) @(negedge sclk);
        #1;
        chk("reset seg", seg, 7'h7F);
        chk("reset dp", dp, 1'b1);
        chk("reset an", an, 4'hF);
        chk("reset frame_start", frame_start, 1'b0);

        // Scan order / full brightness: frame 0 and frame 1 show 1234
        exp_q.push_back(f1234);
        rel_flag = 1'b1;
        reset    = 1'b0;
        step(16'h1234, 4'h0, 4'h0, 4'h0, 2'd3, 1'b0, f1234);

        // Snapshot coherence: change digits while digit 2 of frame 1 is lit
        wait_q_empty("frame 1 start");
        wait_an("digit2 lit", 4'b1011, 1'b0);
        digits = 16'h5678;
        exp_q.push_back(mk(c_FIVE, c_SIX, c_SEVEN, c_EIGHT, 4'hF, 2'd3));

        // Dimmest brightness
        step(16'h5678, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0,
             mk(c_FIVE, c_SIX, c_SEVEN, c_EIGHT, 4'hF, 2'd0));

        // Leading-zero suppression and decode
        step(16'h0070, 4'h0, 4'h0, 4'h0, 2'd3, 1'b1,
             mk(c_DARK, c_DARK, c_SEVEN, c_ZERO, 4'hF, 2'd3));
        step(16'h000C, 4'h0, 4'h0, 4'h0, 2'd3, 1'b1,
             mk(c_DARK, c_DARK, c_DARK, c_DASH, 4'hF, 2'd3));
        wait_q_empty("hex frame start");
        wait_an("hex digit0 lit", 4'b1110, 1'b1);
        chk("hex C seg", seg_h, c_HEX_C);

        // A decimal point stops the zero run; blank darkens a digit
        step(16'h0000, 4'b0100, 4'b0010, 4'h0, 2'd3, 1'b1,
             mk(c_DARK, c_ZERO, c_DARK, c_ZERO, 4'b1011, 2'd3));
        drain("drain 1");

        // Reset at scnt 7 of digit 1 takes effect without a clock edge
        wait_an("digit1 lit", 4'b1101, 1'b0);
        repeat (6) @(posedge sclk);
        #1;
        chk("pre-reset an", an, 4'b1101);
        reset = 1'b1;
        #1;
        chk("async reset seg", seg, 7'h7F);
        chk("async reset dp", dp, 1'b1);
        chk("async reset an", an, 4'hF);
        chk("async reset frame_start", frame_start, 1'b0);
        repeat (3) @(negedge sclk);
        #1;

        // Blink on digit 0: frames 0-1 lit, 2-3 dark, 4 lit
        digits     = 16'h1234;
        dp_in      = 4'h0;
        blank_mask = 4'h0;
        blink_mask = 4'b0001;
        brightness = 2'd3;
        lz_suppress = 1'b0;
        exp_q.push_back(f1234);
        rel_flag = 1'b1;
        reset    = 1'b0;
        step(16'h1234, 4'h0, 4'h0, 4'b0001, 2'd3, 1'b0, f1234);
        step(16'h1234, 4'h0, 4'h0, 4'b0001, 2'd3, 1'b0, f1234_b0dark);
        step(16'h1234, 4'h0, 4'h0, 4'b0001, 2'd3, 1'b0, f1234_b0dark);
        step(16'h1234, 4'h0, 4'h0, 4'b0001, 2'd3, 1'b0, f1234);
        drain("drain 2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
